sram_sdp: RTL

Parametrised simple-dual-port on-chip SRAM, the successor to the single-port image buffer SRAM.
- One write port and one read port, usable in the same cycle.
- Per-byte write enables, configurable read latency and read-during-write mode.
- Built-in clear engine fills memory with INIT_VAL after reset or on request.
- Sits between the image loader (write side) and the pixel-processing pipeline (read side).

---
 rtl/sram_pkg.sv | 18 +
 rtl/sram_sdp_clear_fsm.sv | 57 +++++
 rtl/sram_sdp.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM slice.
package sram_pkg;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  localparam int BYTE_W = 8;

  // Lanes per data word; the SRAM requires D_WIDTH to be a multiple of 8.
  function automatic int byte_lanes(input int d_width);
    return d_width / BYTE_W;
  endfunction

  // Even-parity bit for one stored byte.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_sdp_clear_fsm.sv
// Clear engine for sram_sdp: walks caddr 0..DEPTH-1 after reset or a clr request.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | writing INIT_VAL to mem[caddr], one word per cycle, busy=1
// S_READY | ports open, busy=0; clr restarts the sweep from address 0
module sram_sdp_clear_fsm
  import sram_pkg::*;
#(
  parameter int A_WIDTH = 4,
  parameter int DEPTH   = 2**A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  output logic               busy,
  output logic               cwe,
  output logic [A_WIDTH-1:0] caddr
);

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
      caddr <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          if (caddr == A_WIDTH'(DEPTH - 1)) begin
            state <= S_READY;
            caddr <= '0;
            busy  <= 1'b0;
          end else begin
            caddr <= caddr + A_WIDTH'(1);
          end
        end
        S_READY: begin
          if (clr) begin
            state <= S_CLEAR;
            caddr <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          caddr <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign cwe = (state == S_CLEAR);

endmodule

// File: rtl/sram_sdp.sv
// Simple-dual-port SRAM with byte enables, optional output register and clear engine.
// Build with SRAM_SDP_PARITY_EN to store per-byte even parity and report it on perr.
module sram_sdp
  import sram_pkg::*;
#(
  parameter int                 D_WIDTH  = 8,
  parameter int                 A_WIDTH  = 4,
  parameter int                 DEPTH    = 2**A_WIDTH,
  parameter int                 OUT_REG  = 0,
  parameter int                 RDW_NEW  = 0,
  parameter logic [D_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  output logic                       busy,
  input  logic                       wcen,
  input  logic [byte_lanes(D_WIDTH)-1:0] wbe,
  input  logic [A_WIDTH-1:0]         wa,
  input  logic [D_WIDTH-1:0]         wd,
  input  logic                       rcen,
  input  logic [A_WIDTH-1:0]         ra,
  output logic [D_WIDTH-1:0]         q,
  output logic                       q_valid,
  output logic                       perr
);

  localparam int BYTES = byte_lanes(D_WIDTH);

  logic               cwe;
  logic [A_WIDTH-1:0] caddr;

  sram_sdp_clear_fsm #(
    .A_WIDTH(A_WIDTH),
    .DEPTH  (DEPTH)
  ) u_clear (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .busy (busy),
    .cwe  (cwe),
    .caddr(caddr)
  );

  logic [D_WIDTH-1:0] mem [DEPTH];

  logic wa_ok, ra_ok, wr_acc, rd_acc, rdw_hit;

  assign wa_ok   = int'(wa) < DEPTH;
  assign ra_ok   = int'(ra) < DEPTH;
  assign wr_acc  = !rst && !busy && !wcen && wa_ok;
  assign rd_acc  = !rst && !busy && !rcen;
  assign rdw_hit = (RDW_NEW != 0) && wr_acc && ra_ok && (wa == ra);

  // Clear writes win; the write port is already locked out while busy.
  always_ff @(posedge clk) begin
    if (cwe) begin
      mem[caddr] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wbe[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

`ifdef SRAM_SDP_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cwe) begin
      for (int i = 0; i < BYTES; i++) par_mem[caddr][i] <= byte_parity(INIT_VAL[8*i +: 8]);
    end else if (wr_acc) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wbe[i]) par_mem[wa][i] <= byte_parity(wd[8*i +: 8]);
      end
    end
  end
`endif

  logic [D_WIDTH-1:0] rd_word;
  logic               rd_perr;

  // Bytes merged from wd are fresh, so only untouched bytes can flag parity.
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (ra_ok) begin
      rd_word = mem[ra];
`ifdef SRAM_SDP_PARITY_EN
      for (int i = 0; i < BYTES; i++) begin
        if (!(rdw_hit && wbe[i]) &&
            (par_mem[ra][i] != byte_parity(mem[ra][8*i +: 8])))
          rd_perr = 1'b1;
      end
`endif
      if (rdw_hit) begin
        for (int i = 0; i < BYTES; i++) begin
          if (wbe[i]) rd_word[8*i +: 8] = wd[8*i +: 8];
        end
      end
    end
  end

  logic [D_WIDTH-1:0] q1;
  logic               v1, p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= '0;
      v1 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) begin
        q1 <= rd_word;
        p1 <= rd_perr;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [D_WIDTH-1:0] q2;
      logic               v2, p2;

      always_ff @(posedge clk) begin
        if (rst) begin
          q2 <= '0;
          v2 <= 1'b0;
          p2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            q2 <= q1;
            p2 <= p1;
          end
        end
      end

      assign q       = q2;
      assign q_valid = v2;
      assign perr    = p2 & v2;
    end else begin : g_noreg
      assign q       = q1;
      assign q_valid = v1;
      assign perr    = p1 & v1;
    end
  endgenerate

endmodule
